// File: rtl/conv_channel_sched_if.sv
// Handshake and data bundle between the channel scheduler, the window
// buffer / shared filter3x3 on the fetch side, and the downstream consumer.
interface conv_channel_sched_if #(
  parameter int WIDTH = 10
) ();

  logic                    fetch_vld;
  logic                    fetch_rdy;
  logic [3:0]              fetch_ch;
  logic [7:0]              fetch_row;
  logic [7:0]              fetch_col;
  logic                    psum_vld;
  logic signed [WIDTH-1:0] psum;
  logic                    out_vld;
  logic                    out_rdy;
  logic signed [WIDTH-1:0] out_data;

  // Scheduler side
  modport master (
    output fetch_vld, fetch_ch, fetch_row, fetch_col,
    input  fetch_rdy,
    input  psum_vld, psum,
    output out_vld, out_data,
    input  out_rdy
  );

  // Window buffer / filter / consumer side
  modport slave (
    input  fetch_vld, fetch_ch, fetch_row, fetch_col,
    output fetch_rdy,
    output psum_vld, psum,
    input  out_vld, out_data,
    output out_rdy
  );

endinterface

// File: rtl/conv_channel_sched.sv
// Per-pixel channel scheduler for a shared filter3x3: issues one window
// fetch per input channel, accumulates the returned partial sums, applies
// clip/wrap and optional leaky ReLU, then hands the pixel downstream.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start; config latched on start
// ISSUE  | issuing N_CH window fetches for the current pixel
// DRAIN  | all fetches issued, waiting for remaining psums
// POST   | one cycle: clip/wrap + leaky ReLU into out_data
// OUT    | out_vld held until downstream accepts
// DONE   | one-cycle done pulse, then back to IDLE
module conv_channel_sched #(
  parameter int WIDTH = 10,
  parameter int N_CH  = 4,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic                 i_cfg_clip,
  input  logic                 i_cfg_relu,
  input  logic [7:0]           i_cfg_relu_c,
  conv_channel_sched_if.master bus,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int AW = 2*WIDTH + 1;
  localparam int PW = WIDTH + 9;

  localparam logic signed [WIDTH-1:0] OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [AW-1:0]    ACC_MAX = {{(WIDTH+1){1'b0}}, OUT_MAX};
  localparam logic signed [AW-1:0]    ACC_MIN = {{(WIDTH+1){1'b1}}, OUT_MIN};

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_DRAIN, S_POST, S_OUT, S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [4:0]              r_ch;
  logic [4:0]              r_rcv;
  logic [7:0]              r_row;
  logic [7:0]              r_col;
  logic signed [AW-1:0]    r_acc;
  logic                    r_clip;
  logic                    r_relu;
  logic [7:0]              r_relu_c;
  logic signed [WIDTH-1:0] r_out_data;

  logic                    w_fetch_xfer;
  logic                    w_last_fetch;
  logic                    w_psum_take;
  logic [4:0]              w_rcv_nxt;
  logic                    w_rcv_full;
  logic                    w_out_xfer;
  logic                    w_last_col;
  logic                    w_last_row;
  logic                    w_fetch_vld;
  logic                    w_out_vld;
  logic                    w_busy;
  logic                    w_done;
  logic signed [WIDTH-1:0] w_val;
  logic signed [WIDTH-1:0] w_post;
  logic signed [PW-1:0]    w_prod;

  assign w_fetch_xfer = (r_state == S_ISSUE) && bus.fetch_rdy;
  assign w_last_fetch = w_fetch_xfer && (r_ch == 5'(N_CH - 1));
  // psums only count while a pixel is being gathered; stragglers from an
  // aborted frame land in IDLE and are dropped here.
  assign w_psum_take  = bus.psum_vld && ((r_state == S_ISSUE) || (r_state == S_DRAIN));
  assign w_rcv_nxt    = r_rcv + {4'd0, w_psum_take};
  assign w_rcv_full   = (w_rcv_nxt >= 5'(N_CH));
  assign w_out_xfer   = (r_state == S_OUT) && bus.out_rdy;
  assign w_last_col   = (r_col == 8'(IMG_W - 1));
  assign w_last_row   = (r_row == 8'(IMG_H - 1));

  assign bus.fetch_vld = w_fetch_vld;
  assign bus.fetch_ch  = r_ch[3:0];
  assign bus.fetch_row = r_row;
  assign bus.fetch_col = r_col;
  assign bus.out_vld   = w_out_vld;
  assign bus.out_data  = r_out_data;
  assign o_busy        = w_busy;
  assign o_done        = w_done;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    w_fetch_vld = 1'b0;
    w_out_vld   = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (i_start) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_fetch_vld = 1'b1;
        if (w_last_fetch) w_state_nxt = w_rcv_full ? S_POST : S_DRAIN;
      end
      S_DRAIN: begin
        if (w_rcv_full) w_state_nxt = S_POST;
      end
      S_POST: w_state_nxt = S_OUT;
      S_OUT: begin
        w_out_vld = 1'b1;
        if (w_out_xfer) w_state_nxt = (w_last_row && w_last_col) ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Post-processing: saturate or wrap, then leaky ReLU on negatives
  always_comb begin
    w_val = r_acc[WIDTH-1:0];
    if (r_clip) begin
      if (r_acc > ACC_MAX)      w_val = OUT_MAX;
      else if (r_acc < ACC_MIN) w_val = OUT_MIN;
    end
    // Slope is unsigned, so zero-extend it before the signed multiply.
    w_prod = PW'(w_val) * PW'($signed({1'b0, r_relu_c}));
    w_post = w_val;
    if (r_relu && w_val[WIDTH-1]) w_post = WIDTH'(w_prod >>> 8);
  end

  // Counters, accumulator, latched config and output register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ch       <= '0;
      r_rcv      <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_acc      <= '0;
      r_clip     <= 1'b0;
      r_relu     <= 1'b0;
      r_relu_c   <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_clip   <= i_cfg_clip;
            r_relu   <= i_cfg_relu;
            r_relu_c <= i_cfg_relu_c;
            r_ch     <= '0;
            r_rcv    <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_acc    <= '0;
          end
        end
        S_ISSUE, S_DRAIN: begin
          if (w_fetch_xfer) r_ch <= r_ch + 5'd1;
          if (w_psum_take) begin
            r_acc <= r_acc + AW'(bus.psum);
            r_rcv <= w_rcv_nxt;
          end
        end
        S_POST: r_out_data <= w_post;
        S_OUT: begin
          if (w_out_xfer) begin
            r_acc <= '0;
            r_ch  <= '0;
            r_rcv <= '0;
            if (w_last_col) begin
              r_col <= '0;
              r_row <= w_last_row ? 8'd0 : r_row + 8'd1;
            end else begin
              r_col <= r_col + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_channel_sched.sv
// Scoreboard bench for conv_channel_sched: a behavioural filter returns
// psums a programmable number of cycles after each fetch, expected pixels
// are queued at frame start and popped on each output acceptance.
module tb_conv_channel_sched;

  localparam int WIDTH = 10;
  localparam int N_CH  = 4;
  localparam int IMG_W = 2;
  localparam int IMG_H = 2;
  localparam int NPIX  = IMG_W * IMG_H;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       cfg_clip;
  logic       cfg_relu;
  logic [7:0] cfg_relu_c;
  logic       busy;
  logic       done;

  conv_channel_sched_if #(.WIDTH(WIDTH)) bus ();

  conv_channel_sched #(
    .WIDTH(WIDTH), .N_CH(N_CH), .IMG_W(IMG_W), .IMG_H(IMG_H)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (start),
    .i_cfg_clip   (cfg_clip),
    .i_cfg_relu   (cfg_relu),
    .i_cfg_relu_c (cfg_relu_c),
    .bus          (bus),
    .o_busy       (busy),
    .o_done       (done)
  );

  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_val(input string tag, input int act, input int exp);
    chk_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- filter model ----------------
  int psum_tbl [N_CH];
  int filt_lat = 1;
  int cyc = 0;
  int fq_val [$];
  int fq_due [$];

  initial begin
    bus.psum_vld = 1'b0;
    bus.psum     = '0;
    forever begin
      @(negedge clk);
      if (bus.fetch_vld && bus.fetch_rdy && !reset) begin
        fq_val.push_back(psum_tbl[int'(bus.fetch_ch) % N_CH]);
        fq_due.push_back(cyc + filt_lat);
      end
      @(posedge clk);
      cyc++;
      #1;
      bus.psum_vld = 1'b0;
      if (fq_due.size() > 0 && fq_due[0] <= cyc) begin
        void'(fq_due.pop_front());
        bus.psum     = WIDTH'(fq_val.pop_front());
        bus.psum_vld = 1'b1;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int exp_pixel(input bit clip, input bit relu, input int c);
    int s, v, lim;
    longint p;
    s = 0;
    for (int i = 0; i < N_CH; i++) s += psum_tbl[i];
    lim = 1 << (WIDTH - 1);
    if (clip) begin
      v = (s > lim - 1) ? lim - 1 : ((s < -lim) ? -lim : s);
    end else begin
      v = s & ((1 << WIDTH) - 1);
      if (v >= lim) v -= (1 << WIDTH);
    end
    if (relu && v < 0) begin
      p = longint'(v) * longint'(c);
      v = int'(p >>> 8);
    end
    return v;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int sb [$];
  bit mon_en = 1'b0;
  bit exp_done, busy_chk, hold, lat_chk;
  int hold_data, exp_ch, exp_row, exp_col, xfer_cnt, out_cnt, last_acc;
  int done_cnt = 0;

  task automatic mon_clear();
    sb.delete();
    exp_ch = 0; exp_row = 0; exp_col = 0;
    xfer_cnt = 0; out_cnt = 0;
    exp_done = 1'b0; busy_chk = 1'b0; hold = 1'b0;
    last_acc = -1;
  endtask

  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_done || done) check_val("done_pulse", int'(done), int'(exp_done));
        if (done) done_cnt++;
        if (busy_chk) check_val("busy_after_done", int'(busy), 0);
        busy_chk = done;
        exp_done = 1'b0;

        if (hold) begin
          check_val("hold_vld", int'(bus.out_vld), 1);
          check_val("hold_data", int'($signed(bus.out_data)), hold_data);
        end
        hold      = bus.out_vld && !bus.out_rdy;
        hold_data = int'($signed(bus.out_data));

        if (bus.fetch_vld && bus.fetch_rdy) begin
          check_val("fetch_ch", int'(bus.fetch_ch), exp_ch);
          check_val("fetch_row", int'(bus.fetch_row), exp_row);
          check_val("fetch_col", int'(bus.fetch_col), exp_col);
          xfer_cnt++;
          exp_ch++;
          if (exp_ch == N_CH) begin
            exp_ch = 0;
            if (exp_col == IMG_W - 1) begin
              exp_col = 0;
              exp_row++;
            end else begin
              exp_col++;
            end
          end
        end

        if (bus.out_vld && bus.out_rdy) begin
          out_cnt++;
          if (sb.size() == 0) begin
            check_val("sb_nonempty", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            check_val("out_data", int'($signed(bus.out_data)), e);
            if (sb.size() == 0) exp_done = 1'b1;
          end
          if (lat_chk && last_acc >= 0) check_val("pix_latency", cyc - last_acc, N_CH + 3);
          last_acc = cyc;
        end
      end
    end
  end

  // ---------------- frame driver ----------------
  task automatic run_frame(input bit clip, input bit relu, input int c,
                           input bit bp, input bit restart);
    int k, ov, target, ev;
    mon_clear();
    target = done_cnt + 1;
    ev = exp_pixel(clip, relu, c);
    for (int i = 0; i < NPIX; i++) sb.push_back(ev);
    @(posedge clk); #1;
    cfg_clip      = clip;
    cfg_relu      = relu;
    cfg_relu_c    = 8'(c);
    start         = 1'b1;
    bus.fetch_rdy = 1'b1;
    bus.out_rdy   = !bp;
    k  = 0;
    ov = 0;
    while (done_cnt < target && k < 400) begin
      @(posedge clk); #1;
      k++;
      start      = 1'b0;
      cfg_clip   = ~clip;
      cfg_relu   = ~relu;
      cfg_relu_c = ~(8'(c));
      if (restart && (k == 10 || k == 25)) start = 1'b1;
      bus.fetch_rdy = !(bp && k >= 2 && k < 5);
      if (bus.out_vld) begin
        ov++;
        bus.out_rdy = !(bp && ov <= 5);
      end else begin
        ov = 0;
        bus.out_rdy = !bp;
      end
    end
    start = 1'b0;
    check_val("frame_done", done_cnt, target);
    check_val("out_count", out_cnt, NPIX);
    check_val("sb_left", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic set_psums(input int a, input int b, input int c, input int d);
    psum_tbl[0] = a; psum_tbl[1] = b; psum_tbl[2] = c; psum_tbl[3] = d;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    reset = 1'b1; start = 1'b0;
    cfg_clip = 1'b0; cfg_relu = 1'b0; cfg_relu_c = '0;
    bus.fetch_rdy = 1'b0; bus.out_rdy = 1'b0;
    lat_chk = 1'b0;
    set_psums(0, 0, 0, 0);
    mon_clear();

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_fetch_vld", int'(bus.fetch_vld), 0);
    check_val("rst_fetch_ch", int'(bus.fetch_ch), 0);
    check_val("rst_fetch_row", int'(bus.fetch_row), 0);
    check_val("rst_fetch_col", int'(bus.fetch_col), 0);
    check_val("rst_out_vld", int'(bus.out_vld), 0);
    check_val("rst_out_data", int'($signed(bus.out_data)), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // basic sum, ideal handshakes, per-pixel latency
    set_psums(100, 100, 100, 100);
    lat_chk = 1'b1;
    run_frame(1'b1, 1'b0, 0, 1'b0, 1'b0);
    lat_chk = 1'b0;

    // saturation vs wrap
    set_psums(300, 300, 300, 300);
    run_frame(1'b1, 1'b0, 0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, 0, 1'b0, 1'b0);

    // leaky ReLU: exact, saturated-negative, and rounding toward -inf
    set_psums(-50, -50, -50, -50);
    run_frame(1'b1, 1'b1, 64, 1'b0, 1'b0);
    set_psums(-300, -300, -300, -300);
    run_frame(1'b1, 1'b1, 128, 1'b0, 1'b0);
    set_psums(-25, -25, -25, -26);
    run_frame(1'b0, 1'b1, 200, 1'b0, 1'b0);
    set_psums(-200, 150, -120, 70);
    run_frame(1'b1, 1'b0, 200, 1'b0, 1'b0);

    // backpressure on both fetch and output
    set_psums(10, 20, 30, -40);
    run_frame(1'b1, 1'b0, 0, 1'b1, 1'b0);

    // reset in DRAIN with two psums outstanding
    set_psums(50, 60, 70, 80);
    filt_lat = 3;
    mon_clear();
    @(posedge clk); #1;
    start = 1'b1; cfg_clip = 1'b1; cfg_relu = 1'b0;
    bus.fetch_rdy = 1'b1; bus.out_rdy = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (xfer_cnt < N_CH && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check_val("rst_mid_xfers", xfer_cnt, N_CH);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_fetch_vld", int'(bus.fetch_vld), 0);
    check_val("abort_out_vld", int'(bus.out_vld), 0);
    check_val("abort_out_data", int'($signed(bus.out_data)), 0);
    repeat (6) @(posedge clk);
    #1;
    check_val("late_psum_busy", int'(busy), 0);
    check_val("late_psum_out_vld", int'(bus.out_vld), 0);
    check_val("late_psum_pending", fq_due.size(), 0);
    filt_lat = 1;
    set_psums(1, 2, 3, 4);
    run_frame(1'b1, 1'b0, 0, 1'b0, 1'b0);

    // start while busy must not restart or extend the frame
    set_psums(7, 8, 9, 10);
    run_frame(1'b1, 1'b0, 0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/conv_channel_sched.md
CONV_CHANNEL_SCHED -- requirements
Module: conv_channel_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, data width of filter partial sums and of the output.
REQ-002 The block SHALL have parameter N_CH, default 4, input channels summed per output pixel (2..16).
REQ-003 The block SHALL have parameter IMG_W, default 8, output columns per frame (1..256).
REQ-004 The block SHALL have parameter IMG_H, default 8, output rows per frame (1..256).
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle frame start request.
REQ-008 cfg_clip  in  1  saturate result when 1, truncate when 0.
REQ-009 cfg_relu  in  1  enable leaky ReLU.
REQ-010 cfg_relu_c  in  8  leaky slope, unsigned Q0.8.
REQ-011 fetch_vld  out  1  request to window buffer for one 3x3 window.
REQ-012 fetch_rdy  in  1  window buffer accepts request.
REQ-013 fetch_ch  out  4  channel index of request.
REQ-014 fetch_row / fetch_col  out  8 each  output pixel coordinates of request.
REQ-015 psum_vld  in  1  shared filter3x3 result valid.
REQ-016 psum  in  WIDTH  signed filter3x3 result.
REQ-017 out_vld  out  1  pixel result valid.
REQ-018 out_rdy  in  1  downstream accepts result.
REQ-019 out_data  out  WIDTH  signed pixel result.
REQ-020 busy  out  1  high from start acceptance to done.
REQ-021 done  out  1  one-cycle pulse after the last pixel is accepted.

Function
REQ-022 The FSM SHALL have states IDLE, ISSUE, DRAIN, POST, OUT, DONE.
REQ-023 In IDLE, start=1 SHALL latch cfg_clip, cfg_relu, cfg_relu_c, clear row/col/channel counters and accumulator, and move to ISSUE; cfg inputs SHALL be ignored at all other times.
REQ-024 start SHALL be ignored in any state other than IDLE.
REQ-025 In ISSUE, fetch_vld SHALL be 1 with fetch_ch = channel counter; a request transfers when fetch_vld and fetch_rdy are both 1, which increments the channel counter.
REQ-026 After the transfer with fetch_ch = N_CH-1, the FSM SHALL go to DRAIN; fetch_row/fetch_col SHALL hold the current pixel for all N_CH requests.
REQ-027 In ISSUE and DRAIN, each psum_vld=1 SHALL add sign-extended psum to a signed 2*WIDTH+1-bit accumulator and increment a received count; psum_vld in any other state SHALL be ignored.
REQ-028 When the received count reaches N_CH (including a psum arriving in the same cycle as the last fetch transfer), the FSM SHALL go to POST the next cycle.
REQ-029 POST SHALL last exactly one cycle and register out_data; the FSM then goes to OUT.
REQ-030 cfg_clip=1: value = accumulator saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; cfg_clip=0: value = accumulator low WIDTH bits (wrap).
REQ-031 cfg_relu=1 and value negative: out_data = arithmetic (value*cfg_relu_c)>>>8; otherwise out_data = value.
REQ-032 In OUT, out_vld SHALL be 1 and out_data stable until out_rdy=1; on acceptance the accumulator and counts clear.
REQ-033 On acceptance, col increments; at col=IMG_W-1 col wraps to 0 and row increments; at row=IMG_H-1 and col=IMG_W-1 the FSM goes to DONE, otherwise to ISSUE.
REQ-034 DONE SHALL assert done for exactly one cycle, deassert busy, and return to IDLE.
REQ-035 busy SHALL be 1 in ISSUE, DRAIN, POST, OUT, DONE.
REQ-036 Minimum per-pixel latency with fetch_rdy=1, one-cycle filter, out_rdy=1 SHALL be N_CH+3 cycles.

Reset
REQ-037 reset=1 SHALL force IDLE and clear counters, accumulator and latched cfg on the same edge, from any state including mid-frame.
REQ-038 The following outputs SHALL be 0 after reset: fetch_vld, fetch_ch, fetch_row, fetch_col, out_vld, out_data, busy, done.
REQ-039 psum_vld arriving after reset (from in-flight filter work) SHALL be ignored.

Verification
REQ-040 The bench SHALL cover this case: N_CH=4, IMG 2x2, psums 100,100,100,100, clip=1 -> out_data 400 each pixel, 4 outputs, done one cycle after the last acceptance.
REQ-041 The bench SHALL cover this case: psums 300 x4, clip=1 -> out_data 511; clip=0 -> out_data 1200 mod 1024 = 176.
REQ-042 The bench SHALL cover this case: psums -50 x4, relu=1, relu_c=64, clip=1 -> out_data -50.
REQ-043 The bench SHALL cover this case: fetch_rdy low 3 cycles mid-ISSUE and out_rdy low 5 cycles -> fetch_ch order 0..3 preserved and out_data/out_vld held stable.
REQ-044 The bench SHALL cover this case: reset asserted in DRAIN with 2 psums still pending -> IDLE, busy=0; the late psums are ignored; the next start gives correct first pixel.
REQ-045 The bench SHALL cover this case: start pulsed while busy -> ignored, and exactly IMG_W*IMG_H outputs are produced.
